lmu_pchinfo_buf: RTL and testbench
==================================

LMU_PCHINFO_BUF -- requirements
Module: lmu_pchinfo_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameter DEPTH SHALL default to 16 and is the number of entries; it SHALL be a power of 2 and at least 2.
REQ-003 Parameter PCHINFO_BW SHALL default to PCHTYPE_BW+FACEBD_BW+2*OPCODE_BW and is the entry width, packed {pchtype, facebd_n, pchop0, pchop1}.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  upstream entry offered.
REQ-007 in_pchinfo  in  PCHINFO_BW  upstream entry.
REQ-008 in_last  in  1  offered entry is the last patch of its instruction group.
REQ-009 in_ready  out  1  buffer accepts an entry this cycle.
REQ-010 pchinfo_pop  in  1  LMU consumes the head entry.
REQ-011 pchinfo_valid  out  1  head entry is presentable to the LMU.
REQ-012 pchtype / facebd_n / pchop0 / pchop1  out  PCHTYPE_BW / FACEBD_BW / OPCODE_BW / OPCODE_BW  head entry fields.
REQ-013 pchinfo_rdlast  out  1  head entry is the last of its group.
REQ-014 grp_cnt  out  $clog2(DEPTH)+1  number of complete groups held.
REQ-015 buf_err  out  1  sticky protocol-error flag.

Function
REQ-016 A push SHALL occur when in_valid & in_ready; in_ready SHALL be ~full; a push at full SHALL NOT occur, even if a pop occurs in the same cycle.
REQ-017 Each entry SHALL store in_pchinfo plus in_last; the head fields SHALL be read combinationally at rd_ptr; a pushed entry SHALL be visible at the head no earlier than the next cycle.
REQ-018 A pop SHALL occur when pchinfo_pop & pchinfo_valid; a pchinfo_pop without pchinfo_valid SHALL be ignored.
REQ-019 Pointers SHALL wrap modulo DEPTH; occupancy count SHALL be 0..DEPTH; simultaneous push and pop SHALL leave the count unchanged.
REQ-020 grp_cnt SHALL increment on a push with in_last=1, SHALL decrement on a pop of an entry whose last bit is 1, and SHALL be unchanged when both occur in the same cycle.
REQ-021 FSM states: EMPTY (count=0), HOLD (count>0, grp_cnt=0), READY (grp_cnt>0, no group started), DRAIN (first entry of a group popped, its last entry not yet popped).
REQ-022 Transitions: EMPTY->HOLD on a push without last; EMPTY/HOLD->READY when grp_cnt becomes >0; READY->DRAIN on a pop with last=0; READY stays in READY on a pop with last=1 if grp_cnt remains >0, else goes to HOLD or EMPTY by count; DRAIN->READY/HOLD/EMPTY on a pop with last=1, selected by the post-pop grp_cnt and count.
REQ-023 pchinfo_valid SHALL be 1 only in READY or DRAIN; pchinfo_rdlast SHALL equal the head last bit when pchinfo_valid=1, else 0.
REQ-024 Data outputs SHALL be 0 when pchinfo_valid=0.
REQ-025 buf_err SHALL set on either of: pchinfo_pop while pchinfo_valid=0 and state is DRAIN; or full with grp_cnt=0 (deadlock). buf_err SHALL clear only on rst.

Reset
REQ-026 On rst: pointers, count and grp_cnt SHALL be 0; state SHALL be EMPTY; buf_err SHALL be 0; in_ready SHALL be 1 from the first cycle after reset; all other outputs SHALL be 0.
REQ-027 rst asserted mid-group SHALL discard all entries, including a partially drained group; inputs SHALL be ignored in the reset cycle.

Configuration
REQ-028 With macro LMU_PCHBUF_ERR_EN defined, REQ-025 detection SHALL be compiled in.
REQ-029 Without LMU_PCHBUF_ERR_EN, buf_err SHALL be tied 0 and the detection logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Push 3 entries with last on the 3rd, pop continuously -> pchinfo_valid=0 until the cycle after the 3rd push; pops return entries 1..3; rdlast=1 only on the 3rd; grp_cnt goes 1->0.
REQ-031 DEPTH=16, push 16 entries with last on each 4th -> in_ready=0 after the 16th push; grp_cnt=4; one pop re-enables in_ready the next cycle.
REQ-032 Same-cycle push(last=1) and pop(last=1), starting at grp_cnt=2 -> grp_cnt stays 2; occupancy unchanged; state stays READY.
REQ-033 Push 16 entries with last=0 -> in_ready=0; pchinfo_valid=0; buf_err=1 with LMU_PCHBUF_ERR_EN defined, buf_err=0 without it.
REQ-034 rst asserted after 2 of 4 pops of a group -> the next cycle shows state EMPTY, grp_cnt=0, pchinfo_valid=0, in_ready=1.
REQ-035 Wrap test: 40 pushes and pops in groups of 5 -> output order matches input order exactly, with rdlast on every 5th entry.

Source files
------------

// File: rtl/lmu_pchinfo_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : lmu_pchinfo_buf_if
//  Purpose  : Push/pop bundle between the patch-info producer, the buffer
//             and the LMU consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface lmu_pchinfo_buf_if #(
    parameter int DEPTH      = 16,
    parameter int PCHTYPE_BW = 3,
    parameter int FACEBD_BW  = 1,
    parameter int OPCODE_BW  = 8,
    parameter int PCHINFO_BW = PCHTYPE_BW + FACEBD_BW + 2*OPCODE_BW
);
    logic                      in_valid;
    logic [PCHINFO_BW-1:0]     in_pchinfo;
    logic                      in_last;
    logic                      in_ready;
    logic                      pchinfo_pop;
    logic                      pchinfo_valid;
    logic [PCHTYPE_BW-1:0]     pchtype;
    logic [FACEBD_BW-1:0]      facebd_n;
    logic [OPCODE_BW-1:0]      pchop0;
    logic [OPCODE_BW-1:0]      pchop1;
    logic                      pchinfo_rdlast;
    logic [$clog2(DEPTH):0]    grp_cnt;
    logic                      buf_err;

    modport master (
        output in_valid, in_pchinfo, in_last, pchinfo_pop,
        input  in_ready, pchinfo_valid, pchtype, facebd_n, pchop0, pchop1,
        input  pchinfo_rdlast, grp_cnt, buf_err
    );

    modport slave (
        input  in_valid, in_pchinfo, in_last, pchinfo_pop,
        output in_ready, pchinfo_valid, pchtype, facebd_n, pchop0, pchop1,
        output pchinfo_rdlast, grp_cnt, buf_err
    );
endinterface
`default_nettype wire

// File: rtl/lmu_pchinfo_buf.sv
`default_nettype none
// ============================================================================
//  Module   : lmu_pchinfo_buf
//  Purpose  : Patch-info FIFO that only presents entries to the LMU once a
//             complete instruction group is held. Optional protocol-error
//             detection is compiled in with macro LMU_PCHBUF_ERR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lmu_pchinfo_buf #(
    parameter int DEPTH      = 16,
    parameter int PCHTYPE_BW = 3,
    parameter int FACEBD_BW  = 1,
    parameter int OPCODE_BW  = 8,
    parameter int PCHINFO_BW = PCHTYPE_BW + FACEBD_BW + 2*OPCODE_BW
) (
    input  logic               clk,
    input  logic               rst,
    lmu_pchinfo_buf_if.slave   bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_READY = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Each entry carries the payload with the group-last flag in bit 0
    logic [PCHINFO_BW:0]  r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic [c_CW-1:0]      r_grp_cnt;
    state_t               r_state;
    logic                 r_valid;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [PCHINFO_BW:0]  w_head;
    logic                 w_head_last;
    logic [c_CW-1:0]      w_count_nxt;
    logic [c_CW-1:0]      w_grp_nxt;
    logic [PCHINFO_BW-1:0] w_entry;

    assign w_full      = (r_count == c_CW'(DEPTH));
    assign w_push      = bus.in_valid & ~w_full;
    assign w_pop       = bus.pchinfo_pop & r_valid;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[0];

    always_comb begin
        w_count_nxt = r_count;
        w_grp_nxt   = r_grp_cnt;
        if (w_push && !w_pop)
            w_count_nxt = r_count + c_CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - c_CW'(1);
        if ((w_push && bus.in_last) && !(w_pop && w_head_last))
            w_grp_nxt = r_grp_cnt + c_CW'(1);
        else if (!(w_push && bus.in_last) && (w_pop && w_head_last))
            w_grp_nxt = r_grp_cnt - c_CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {bus.in_pchinfo, bus.in_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_grp_cnt <= '0;
            r_state   <= ST_EMPTY;
            r_valid   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count   <= w_count_nxt;
            r_grp_cnt <= w_grp_nxt;
            // A group in progress stays in DRAIN until its last entry leaves
            if ((r_state == ST_DRAIN && !(w_pop && w_head_last)) ||
                (r_state == ST_READY && w_pop && !w_head_last)) begin
                r_state <= ST_DRAIN;
                r_valid <= 1'b1;
            end else if (w_grp_nxt != '0) begin
                r_state <= ST_READY;
                r_valid <= 1'b1;
            end else if (w_count_nxt != '0) begin
                r_state <= ST_HOLD;
                r_valid <= 1'b0;
            end else begin
                r_state <= ST_EMPTY;
                r_valid <= 1'b0;
            end
        end
    end

    assign w_entry            = r_valid ? w_head[PCHINFO_BW:1] : '0;
    assign {bus.pchtype, bus.facebd_n, bus.pchop0, bus.pchop1} = w_entry;
    assign bus.pchinfo_rdlast = r_valid & w_head_last;
    assign bus.pchinfo_valid  = r_valid;
    assign bus.in_ready       = ~w_full;
    assign bus.grp_cnt        = r_grp_cnt;

`ifdef LMU_PCHBUF_ERR_EN
    logic r_buf_err;

    // Full with no complete group can never drain: flag it as deadlock
    always_ff @(posedge clk) begin
        if (rst)
            r_buf_err <= 1'b0;
        else if ((bus.pchinfo_pop && !r_valid && r_state == ST_DRAIN) ||
                 (w_full && r_grp_cnt == '0))
            r_buf_err <= 1'b1;
    end

    assign bus.buf_err = r_buf_err;
`else
    assign bus.buf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lmu_pchinfo_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lmu_pchinfo_buf
//  Purpose  : Randomized and directed self-checking bench for lmu_pchinfo_buf
//             against a queue-based group-FIFO model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lmu_pchinfo_buf;
    localparam int DEPTH = 16;
    localparam int PW    = 3 + 1 + 2*8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    lmu_pchinfo_buf_if #(.DEPTH(DEPTH)) bus ();

    lmu_pchinfo_buf #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: queue of {payload,last}; entries visible whenever a whole group is held
    logic [PW:0] m_q[$];
    int          m_grp = 0;
    bit          m_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit push, pop;
        logic [PW:0] head;
        if (rst) begin
            m_q.delete();
            m_grp = 0;
            m_err = 1'b0;
            return;
        end
`ifdef LMU_PCHBUF_ERR_EN
        if (m_q.size() == DEPTH && m_grp == 0) m_err = 1'b1;
`endif
        push = bus.in_valid && (m_q.size() < DEPTH);
        pop  = bus.pchinfo_pop && (m_grp > 0);
        if (pop) begin
            head = m_q.pop_front();
            if (head[0]) m_grp--;
        end
        if (push) begin
            m_q.push_back({bus.in_pchinfo, bus.in_last});
            if (bus.in_last) m_grp++;
        end
    endtask

    task automatic check_all();
        logic [PW:0] exp_head;
        exp_head = (m_grp > 0) ? m_q[0] : '0;
        chk("in_ready", 64'(bus.in_ready), 64'(m_q.size() < DEPTH));
        chk("pchinfo_valid", 64'(bus.pchinfo_valid), 64'(m_grp > 0));
        chk("head", 64'({bus.pchtype, bus.facebd_n, bus.pchop0, bus.pchop1}), 64'(exp_head[PW:1]));
        chk("rdlast", 64'(bus.pchinfo_rdlast), 64'(exp_head[0]));
        chk("grp_cnt", 64'(bus.grp_cnt), 64'(m_grp));
        chk("buf_err", 64'(bus.buf_err), 64'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input logic [PW-1:0] info, input bit last, input bit pop);
        bus.in_valid    = v;
        bus.in_pchinfo  = info;
        bus.in_last     = last;
        bus.pchinfo_pop = pop;
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic e_err;
        int   pushed, popped, budget;
        drive(0, '0, 0, 0);
        @(negedge clk);
        do_reset();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_valid", 64'(bus.pchinfo_valid), 64'd0);
        chk("rst_grp", 64'(bus.grp_cnt), 64'd0);
        chk("rst_err", 64'(bus.buf_err), 64'd0);

        // Three-entry group with continuous pop request
        for (int i = 1; i <= 3; i++) begin
            chk("g3_valid_pre", 64'(bus.pchinfo_valid), 64'd0);
            drive(1, PW'(i), i == 3, 1);
            step();
        end
        chk("g3_valid", 64'(bus.pchinfo_valid), 64'd1);
        chk("g3_grp1", 64'(bus.grp_cnt), 64'd1);
        drive(0, '0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            chk("g3_order", 64'(bus.pchop1), 64'(i));
            chk("g3_rdlast", 64'(bus.pchinfo_rdlast), 64'(i == 3));
            step();
        end
        chk("g3_grp0", 64'(bus.grp_cnt), 64'd0);
        chk("g3_valid_post", 64'(bus.pchinfo_valid), 64'd0);

        // Fill to full with a group every fourth entry
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(1, PW'(i), (i % 4) == 0, 0);
            step();
        end
        drive(0, '0, 0, 0);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_grp4", 64'(bus.grp_cnt), 64'd4);
        drive(0, '0, 0, 1);
        step();
        drive(0, '0, 0, 0);
        chk("full_reenable", 64'(bus.in_ready), 64'd1);

        // Simultaneous push-last and pop-last at grp_cnt=2
        do_reset();
        drive(1, PW'(7), 1, 0); step();
        drive(1, PW'(8), 1, 0); step();
        chk("simul_pre_grp", 64'(bus.grp_cnt), 64'd2);
        drive(1, PW'(9), 1, 1); step();
        drive(0, '0, 0, 0);
        chk("simul_grp", 64'(bus.grp_cnt), 64'd2);
        chk("simul_valid", 64'(bus.pchinfo_valid), 64'd1);
        chk("simul_head", 64'(bus.pchop1), 64'd8);
        chk("simul_occ", 64'(m_q.size()), 64'd2);

        // Deadlock: full without any complete group
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, PW'(i), 0, 0);
            step();
        end
        drive(0, '0, 0, 1);
        step(); step(); step();
`ifdef LMU_PCHBUF_ERR_EN
        e_err = 1'b1;
`else
        e_err = 1'b0;
`endif
        chk("dl_in_ready", 64'(bus.in_ready), 64'd0);
        chk("dl_valid", 64'(bus.pchinfo_valid), 64'd0);
        chk("dl_err", 64'(bus.buf_err), 64'(e_err));

        // Reset in the middle of draining a group
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1, PW'(i), i == 4, 0);
            step();
        end
        drive(0, '0, 0, 1); step(); step();
        drive(1, PW'(5), 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, '0, 0, 0);
        chk("mid_rst_grp", 64'(bus.grp_cnt), 64'd0);
        chk("mid_rst_valid", 64'(bus.pchinfo_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_err", 64'(bus.buf_err), 64'd0);

        // Pointer wrap: 40 entries in groups of five with random pop gaps
        do_reset();
        pushed = 0; popped = 0; budget = 0;
        while (popped < 40 && budget < 2000) begin
            drive((pushed < 40) && ($urandom_range(0, 3) != 0), PW'(pushed),
                  (pushed % 5) == 4, $urandom_range(0, 9) < 6);
            if (bus.pchinfo_pop && bus.pchinfo_valid) begin
                chk("wrap_order", 64'(bus.pchop1), 64'(popped));
                chk("wrap_last", 64'(bus.pchinfo_rdlast), 64'((popped % 5) == 4));
                popped++;
            end
            if (bus.in_valid && bus.in_ready) pushed++;
            step();
            budget++;
        end
        chk("wrap_done", 64'(popped), 64'd40);

        // Free-running random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 1) == 1, PW'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
